// File: rtl/teak_action_ctrl_pkg.sv
// Shared definitions for the teak action control register block:
// register word offsets (decoded on addr[5:2]), CTRL bit positions and
// the sequencer state encoding.
package teak_action_ctrl_pkg;

    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_GIE      = 4'h1;
    localparam logic [3:0] REG_IER      = 4'h2;
    localparam logic [3:0] REG_ISR      = 4'h3;
    localparam logic [3:0] REG_PARAM_LO = 4'h4;
    localparam logic [3:0] REG_PARAM_HI = 4'h5;
    localparam logic [3:0] REG_CYCLES   = 4'h6;

    localparam int CTRL_AP_START = 0;
    localparam int CTRL_AP_DONE  = 1;
    localparam int CTRL_AP_IDLE  = 2;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_GO   = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_ACK  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/teak_action_seq.sv
// Start/done handshake sequencer for the action, plus the run-cycle
// counter. go_0r and done_0a come straight from flops so the action sees
// glitch-free request/ack lines.
module teak_action_seq
    import teak_action_ctrl_pkg::*;
#(
    parameter int CYCLE_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   go_0a,
    input  logic                   done_0r,
    output logic                   go_0r,
    output logic                   done_0a,
    output logic                   done_evt,
    output seq_state_t             state,
    output logic [CYCLE_CNT_W-1:0] cycles
);

    seq_state_t state_next;

    // Next-state decode; done_evt marks the ACK->IDLE step that completes a run
    always_comb begin
        state_next = state;
        done_evt   = 1'b0;
        case (state)
            SEQ_IDLE: if (start)    state_next = SEQ_GO;
            SEQ_GO:   if (go_0a)    state_next = SEQ_RUN;
            SEQ_RUN:  if (done_0r)  state_next = SEQ_ACK;
            SEQ_ACK:  if (!done_0r) begin
                          state_next = SEQ_IDLE;
                          done_evt   = 1'b1;
                      end
            default:  state_next = SEQ_IDLE;
        endcase
    end

    // State register with handshake outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEQ_IDLE;
            go_0r   <= 1'b0;
            done_0a <= 1'b0;
        end else begin
            state   <= state_next;
            go_0r   <= (state_next == SEQ_GO);
            done_0a <= (state_next == SEQ_ACK);
        end
    end

    // Run-cycle counter: cleared at launch, counts GO and RUN, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= '0;
        end else if (state == SEQ_IDLE && state_next == SEQ_GO) begin
            cycles <= '0;
        end else if ((state == SEQ_GO || state == SEQ_RUN) && cycles != '1) begin
            cycles <= cycles + 1'b1;
        end
    end

endmodule

// File: rtl/teak_action_ctrl_regs.sv
// AXI4-Lite control/status registers for a teak action: CTRL, interrupt
// registers, 64-bit parameter buffer base and a run-cycle counter.
// Optional feature macro: TEAK_ACTION_IRQ_EN enables GIE/IER/ISR and irq;
// without it those registers read 0 and irq is tied low.
module teak_action_ctrl_regs
    import teak_action_ctrl_pkg::*;
#(
    parameter int          CYCLE_CNT_W = 32,
    parameter logic [63:0] PARAM_RST   = 64'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic        go_0r,
    input  logic        go_0a,
    input  logic        done_0r,
    output logic        done_0a,
    output logic [63:0] param_buf_base,
    output logic        irq
);

    logic [1:0]             rst_sync;
    logic                   rst_n;
    logic                   wr_en;
    logic                   rd_en;
    logic [3:0]             wr_addr;
    logic [3:0]             rd_addr;
    logic                   start;
    logic                   done_evt;
    logic                   ap_done;
    logic [31:0]            rd_mux;
    seq_state_t             seq_state;
    logic [CYCLE_CNT_W-1:0] cycles;
    logic                   unused_addr_bits;

    assign rst_n       = rst_sync[1];
    assign wr_en       = s_axi_awready;
    assign rd_en       = s_axi_arready;
    assign wr_addr     = s_axi_awaddr[5:2];
    assign rd_addr     = s_axi_araddr[5:2];
    assign s_axi_rresp = 2'b00;
    assign s_axi_bresp = 2'b00;
    assign start       = wr_en && wr_addr == REG_CTRL && s_axi_wstrb[0]
                         && s_axi_wdata[CTRL_AP_START];
    assign unused_addr_bits = ^{s_axi_araddr[31:6], s_axi_araddr[1:0],
                                s_axi_awaddr[31:6], s_axi_awaddr[1:0]};

    // Reset asserts at once but releases only on a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    teak_action_seq #(.CYCLE_CNT_W(CYCLE_CNT_W)) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .go_0a    (go_0a),
        .done_0r  (done_0r),
        .go_0r    (go_0r),
        .done_0a  (done_0a),
        .done_evt (done_evt),
        .state    (seq_state),
        .cycles   (cycles)
    );

    // Write channel: one-cycle ready pulse, then hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else if (s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b1;
        end else if (s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
        end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
        end
    end

    // Read channel: data is captured on the arready cycle and held until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= 32'h0;
        end else if (s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= rd_mux;
        end else if (s_axi_arvalid && !s_axi_rvalid) begin
            s_axi_arready <= 1'b1;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid  <= 1'b0;
        end
    end

    // Parameter base is frozen while a run is in progress so the action sees a stable value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            param_buf_base <= PARAM_RST;
        end else if (wr_en && seq_state == SEQ_IDLE) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b] && wr_addr == REG_PARAM_LO)
                    param_buf_base[8*b +: 8] <= s_axi_wdata[8*b +: 8];
                if (s_axi_wstrb[b] && wr_addr == REG_PARAM_HI)
                    param_buf_base[32+8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    // ap_done is sticky until a CTRL read; a completion in the same cycle wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            ap_done <= 1'b0;
        else if (done_evt)                     ap_done <= 1'b1;
        else if (rd_en && rd_addr == REG_CTRL) ap_done <= 1'b0;
    end

`ifdef TEAK_ACTION_IRQ_EN
    logic gie;
    logic ier;
    logic isr;

    assign irq = gie & ier & isr;

    // Interrupt registers; ISR clears on a write of 1 unless a completion lands in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gie <= 1'b0;
            ier <= 1'b0;
            isr <= 1'b0;
        end else begin
            if (wr_en && wr_addr == REG_GIE && s_axi_wstrb[0]) gie <= s_axi_wdata[0];
            if (wr_en && wr_addr == REG_IER && s_axi_wstrb[0]) ier <= s_axi_wdata[0];
            if (done_evt)
                isr <= 1'b1;
            else if (wr_en && wr_addr == REG_ISR && s_axi_wstrb[0] && s_axi_wdata[0])
                isr <= 1'b0;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read data selection; unmapped offsets return zero
    always_comb begin
        rd_mux = 32'h0;
        case (rd_addr)
            REG_CTRL: begin
                rd_mux[CTRL_AP_START] = (seq_state != SEQ_IDLE);
                rd_mux[CTRL_AP_DONE]  = ap_done;
                rd_mux[CTRL_AP_IDLE]  = (seq_state == SEQ_IDLE);
            end
`ifdef TEAK_ACTION_IRQ_EN
            REG_GIE:      rd_mux[0] = gie;
            REG_IER:      rd_mux[0] = ier;
            REG_ISR:      rd_mux[0] = isr;
`endif
            REG_PARAM_LO: rd_mux = param_buf_base[31:0];
            REG_PARAM_HI: rd_mux = param_buf_base[63:32];
            REG_CYCLES:   rd_mux = 32'(cycles);
            default:      rd_mux = 32'h0;
        endcase
    end

endmodule
